instr_fetch: RTL

Instruction fetch unit for the RV32 core: generates the sequential PC, issues word reads on the instruction bus, and buffers returned instructions with their PC in a small in-order queue. It sits directly upstream of the instruction decoder, which consumes one `{pc, instruction}` pair per cycle through a valid/ready handshake. Taken branches, jumps and traps redirect it, and all in-flight and buffered fetches are discarded.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 96 +++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Signal bundle between the fetch unit, the instruction bus, the redirect source
// and the decoder. master = fetch unit side, slave = environment side.
interface instr_fetch_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output ibus_req, ibus_addr, if_valid, if_instr, if_pc,
    input  ibus_ready, ibus_rvalid, ibus_rdata, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  ibus_req, ibus_addr, if_valid, if_instr, if_pc,
    output ibus_ready, ibus_rvalid, ibus_rdata, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: sequential PC generation, credit-limited bus reads and an
// in-order {pc, instr} buffer feeding the decoder; redirect flushes everything in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_pcq_rd;
  logic [PW-1:0] r_pcq_wr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_buf_pc    [BUF_DEPTH];
  logic [31:0]   r_buf_instr [BUF_DEPTH];
  logic [31:0]   r_pcq       [BUF_DEPTH];

  logic          w_credit_ok;
  logic          w_accept;
  logic          w_rsp_live;
  logic          w_rsp_drop;
  logic          w_deq;
  logic [CW:0]   w_inflight;

  // Outstanding reads already own a buffer slot, so a response can never overflow.
  assign w_inflight  = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit_ok = (w_inflight < DEPTH_C);

  assign bus.ibus_req  = ~rst & ~bus.redirect & w_credit_ok;
  assign bus.ibus_addr = r_fetch_pc;
  assign bus.if_valid  = (r_count != '0);
  assign bus.if_instr  = r_buf_instr[r_rd_ptr];
  assign bus.if_pc     = r_buf_pc[r_rd_ptr];

  assign w_accept   = bus.ibus_req & bus.ibus_ready;
  assign w_rsp_drop = bus.ibus_rvalid & (r_drop != '0);
  assign w_rsp_live = bus.ibus_rvalid & (r_drop == '0);
  assign w_deq      = bus.if_valid & bus.if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_pcq_rd      <= '0;
      r_pcq_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (bus.redirect) begin
      // Every read still owed after this cycle belongs to the flushed stream.
      r_fetch_pc    <= {bus.redirect_pc[31:2], 2'b00};
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_pcq_rd      <= '0;
      r_pcq_wr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CW'(bus.ibus_rvalid);
      r_drop        <= r_outstanding - CW'(bus.ibus_rvalid);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pcq_wr   <= r_pcq_wr + 1'b1;
      end
      if (w_rsp_live) begin
        r_pcq_rd <= r_pcq_rd + 1'b1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count       <= r_count + CW'(w_rsp_live) - CW'(w_deq);
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(bus.ibus_rvalid);
      r_drop        <= r_drop - CW'(w_rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
    if (w_rsp_live & ~bus.redirect) begin
      r_buf_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
      r_buf_instr[r_wr_ptr] <= bus.ibus_rdata;
    end
  end
endmodule
